// File: rtl/dual_ram_pkg.sv
// dual_ram_pkg: shared FSM state type and read-during-write mode constants
package dual_ram_pkg;
    typedef enum logic {CLEAR, READY} state_t;
    localparam int RDW_READ_FIRST = 0;
    localparam int RDW_WRITE_FIRST = 1;
endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: clear FSM that walks every address once, one word per cycle
module ram_clr_seq
    import dual_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    state_t state, state_nx;
    logic [ADDR_WIDTH:0] cnt, cnt_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // clr is only honoured from READY, so a running clear never restarts
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == CLEAR) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = (cnt == LAST) ? READY : CLEAR;
        end else if (clr) begin
            state_nx = CLEAR;
            cnt_nx   = '0;
        end
    end
    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt[ADDR_WIDTH-1:0];
endmodule

// File: rtl/dual_ram_ext.sv
// dual_ram_ext: two-port RAM with self-clearing sequence, collision flag and selectable read-during-write
module dual_ram_ext
    import dual_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  we1,
    input  logic                  oe1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] d_in1,
    output logic [DATA_WIDTH-1:0] d_out1,
    output logic                  vld1,
    input  logic                  we2,
    input  logic                  oe2,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] d_in2,
    output logic [DATA_WIDTH-1:0] d_out2,
    output logic                  vld2,
    output logic                  coll
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we, rd1, rd2, same, hit, byp1, byp2;
    logic [DATA_WIDTH-1:0] q1, q2;
    ram_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .busy(busy), .clr_addr(clr_addr), .clr_we(clr_we)
    );
    // bypass only matters for the other port's write; a port cannot read while it writes
    always_comb begin
        same = (addr1 == addr2);
        hit  = we1 && we2 && same;
        rd1  = !busy && oe1 && !we1;
        rd2  = !busy && oe2 && !we2;
        byp1 = (RDW_MODE == RDW_WRITE_FIRST) && we2 && same;
        byp2 = (RDW_MODE == RDW_WRITE_FIRST) && we1 && same;
        q1   = byp1 ? d_in2 : mem[addr1];
        q2   = byp2 ? d_in1 : mem[addr2];
    end
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (we1) mem[addr1] <= d_in1;
            if (we2 && !hit) mem[addr2] <= d_in2;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out1 <= '0;
            d_out2 <= '0;
            vld1   <= 1'b0;
            vld2   <= 1'b0;
            coll   <= 1'b0;
        end else begin
            d_out1 <= rd1 ? q1 : '0;
            d_out2 <= rd2 ? q2 : '0;
            vld1   <= rd1;
            vld2   <= rd2;
            coll   <= !busy && hit;
        end
    end
endmodule

// File: doc/dual_ram_ext.md
DUAL_RAM_EXT -- requirements
Module: dual_ram_ext

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (1..64).
REQ-002 Parameter ADDR_WIDTH, default 4, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter RDW_MODE, default 0, cross-port read-during-write mode: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  single-cycle request to zero the whole memory.
REQ-007 busy  output  1  high while the clear sequence runs.
REQ-008 we1, oe1  input  1 each  port-1 write enable, read enable.
REQ-009 addr1  input  ADDR_WIDTH  port-1 address.
REQ-010 d_in1  input  DATA_WIDTH  port-1 write data.
REQ-011 d_out1  output  DATA_WIDTH  port-1 registered read data.
REQ-012 vld1  output  1  port-1 read data valid.
REQ-013 we2, oe2, addr2, d_in2, d_out2, vld2: port 2, same widths and meanings as port 1.
REQ-014 coll  output  1  one-cycle pulse on a dual-write address collision.

Function
REQ-015 FSM states: CLEAR, READY; CLEAR writes 0 to address cnt, then increments cnt; one word per cycle.
REQ-016 CLEAR -> READY on the cycle cnt == DEPTH-1 is written; READY -> CLEAR on clr == 1 with cnt reset to 0.
REQ-017 clr while in CLEAR is ignored; the sequence does not restart.
REQ-018 busy == 1 exactly while state == CLEAR; a full clear takes DEPTH cycles.
REQ-019 While busy, port writes are dropped and port reads are not accepted (vld = 0, d_out = 0).
REQ-020 In READY, a write on port n occurs when wen == 1; the address written takes d_inn at the clock edge.
REQ-021 A read on port n is accepted when oen == 1 and wen == 0; d_outn and vldn = 1 appear one cycle later (latency 1).
REQ-022 When no read is accepted, d_outn is 0 and vldn is 0 on the next cycle.
REQ-023 If both ports write the same address in one cycle, port 1 wins, port 2's write is dropped, and coll = 1 on the following cycle only.
REQ-024 If both ports write different addresses, both writes take effect and coll stays 0.
REQ-025 If one port reads an address the other port writes in the same cycle, RDW_MODE = 0 returns the old word; RDW_MODE = 1 returns the written data (bypass).
REQ-026 Both ports may read the same address simultaneously; both return the same word.
REQ-027 Addresses are ADDR_WIDTH bits wide with no out-of-range case; cnt is ADDR_WIDTH+1 bits wide so it cannot wrap mid-sequence.

Reset
REQ-028 Asserting rst_n low immediately sets state = CLEAR, cnt = 0, d_out1 = d_out2 = 0, vld1 = vld2 = 0, coll = 0, busy = 1.
REQ-029 Memory contents are not reset directly; after rst_n deasserts, the CLEAR sequence zeroes all DEPTH words.
REQ-030 Reset during CLEAR restarts the sequence from address 0.

Structure
REQ-031 Package dual_ram_pkg holds the FSM state enum (CLEAR, READY) and the constants RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1.
REQ-032 One sub-module, ram_clr_seq, contains the FSM and counter and outputs busy, the clear address and the clear write strobe; the storage array and port logic stay in dual_ram_ext.

Verification (DATA_WIDTH = 8, ADDR_WIDTH = 4)
REQ-033 Release reset: busy = 1 for 16 cycles then 0; reading addresses 0..15 returns 0x00 with vld = 1 one cycle after each request.
REQ-034 Port 1 writes 0xA5 to address 3; the next cycle port 2 reads address 3: d_out2 = 0xA5 and vld2 = 1 one cycle after the read.
REQ-035 In one cycle port 1 writes 0x11 and port 2 writes 0x22, both to address 7: coll = 1 for one cycle, and a later read of address 7 returns 0x11.
REQ-036 Address 5 holds 0x0F; port 1 writes 0xF0 to address 5 while port 2 reads address 5: RDW_MODE = 0 gives d_out2 = 0x0F, RDW_MODE = 1 gives d_out2 = 0xF0.
REQ-037 Fill memory, pulse clr, and during CLEAR assert we1 with 0xFF to address 2: busy = 1 for 16 cycles, and all words read 0x00 afterwards.
REQ-038 Assert rst_n low at clear cycle 8, then release: busy = 1 for a full 16 cycles from the release, and d_out, vld and coll stay 0 during reset.
